// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: states, opcodes,
// ALU operation codes and the bundle of decoded control outputs.
package mc_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef struct packed {
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       load_pc;
    logic       pc_src;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle FSM (master) and the datapath/memories (slave).
interface mc_control_fsm_if;
  logic [31:0] instr;
  logic        zero;
  logic        dmem_ack;
  logic        alu_src;
  logic [3:0]  alu_ctrl;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic        load_pc;
  logic        pc_src;
  logic        mem_err;
  logic [2:0]  state;

  modport master (
    input  instr, zero, dmem_ack,
    output alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg,
           reg_write, load_pc, pc_src, mem_err, state
  );

  modport slave (
    output instr, zero, dmem_ack,
    input  alu_src, alu_ctrl, mem_read, mem_write, mem_to_reg,
           reg_write, load_pc, pc_src, mem_err, state
  );
endinterface

// File: rtl/mc_control_fsm_alu_ctrl_dec.sv
// ALU operation decode from opcode/funct3/funct7[5]; purely combinational.
module alu_ctrl_dec
  import mc_control_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_AND;
    case (opcode)
      OP_R, OP_I: begin
        case (funct3)
          // funct7[5] is immediate data for addi, so only R-type sub honours it
          3'b000:         alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:         alu_ctrl = ALU_SLL;
          3'b010, 3'b011: alu_ctrl = ALU_SLT;
          3'b100:         alu_ctrl = ALU_XOR;
          3'b101:         alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:         alu_ctrl = ALU_OR;
          default:        alu_ctrl = ALU_AND;
        endcase
      end
      OP_LW, OP_SW: alu_ctrl = ALU_ADD;
      OP_BEQ:       alu_ctrl = ALU_SUB;
      default:      alu_ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: IF->ID->EX->MEM->WB, decoding the latched instruction
// into Moore-style datapath controls with a bounded wait for data memory.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  mc_control_fsm_if.master  bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t      st, st_nxt;
  logic [31:0] ir;
  logic        branch_taken;
  logic        mem_err;
  logic        timed_out;
  logic [7:0]  wait_cnt;
  logic [3:0]  dec_alu;
  ctrl_t       c;

  logic [6:0] opcode;
  logic       mem_op;
  logic       wait_exp;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign mem_op    = is_mem_op(opcode);
  assign wait_exp  = (wait_cnt == WAIT_LAST);
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  alu_ctrl_dec u_dec (
    .opcode   (opcode),
    .funct3   (ir[14:12]),
    .funct7_5 (ir[30]),
    .alu_ctrl (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) st <= S_IF;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = S_IF;
    case (st)
      S_IF:  st_nxt = S_ID;
      S_ID:  st_nxt = S_EX;
      S_EX:  st_nxt = S_MEM;
      S_MEM: st_nxt = (!mem_op || bus.dmem_ack || wait_exp) ? S_WB : S_MEM;
      S_WB:  st_nxt = S_IF;
      default: st_nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir           <= '0;
      branch_taken <= 1'b0;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      if (st == S_ID) ir <= bus.instr;
      if (st == S_EX) branch_taken <= (opcode == OP_BEQ) && bus.zero;
      if (st == S_MEM && mem_op) begin
        if (bus.dmem_ack || wait_exp) begin
          wait_cnt <= '0;
          if (!bus.dmem_ack) begin
            mem_err   <= 1'b1;
            timed_out <= 1'b1;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end
      // timed_out is per-instruction; mem_err is the sticky copy
      if (st == S_WB) timed_out <= 1'b0;
    end
  end

  always_comb begin
    c = '0;
    if (st inside {S_EX, S_MEM, S_WB}) begin
      c.alu_src  = (opcode == OP_I) || mem_op;
      c.alu_ctrl = dec_alu;
    end
    case (st)
      S_MEM: begin
        c.mem_read  = (opcode == OP_LW);
        c.mem_write = (opcode == OP_SW);
      end
      S_WB: begin
        c.mem_to_reg = (opcode == OP_LW);
        c.reg_write  = (opcode == OP_R) || (opcode == OP_I) ||
                       ((opcode == OP_LW) && !timed_out);
        c.load_pc    = 1'b1;
        c.pc_src     = branch_taken;
      end
      default: ;
    endcase
  end

  assign bus.alu_src    = c.alu_src;
  assign bus.alu_ctrl   = c.alu_ctrl;
  assign bus.mem_read   = c.mem_read;
  assign bus.mem_write  = c.mem_write;
  assign bus.mem_to_reg = c.mem_to_reg;
  assign bus.reg_write  = c.reg_write;
  assign bus.load_pc    = c.load_pc;
  assign bus.pc_src     = c.pc_src;
  assign bus.mem_err    = mem_err;
  assign bus.state      = st;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_fsm_if bif ();

  mc_control_fsm #(.MEM_WAIT_MAX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       src;
    logic [3:0] alu;
    logic       rd, wr, m2r, rw, lpc, pcs, err;
    logic       chk;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    int          ack;
    int          mcyc;
    logic [3:0]  alu;
    logic        achk, src, lw, sw, rw, pcs, err;
  } row_t;

  exp_t  q[$];
  row_t  tbl[$];
  int    checks = 0;
  int    errors = 0;
  string cur_tag = "reset";
  logic  err_model = 1'b0;
  logic  after_rst = 1'b0;

  function automatic row_t mk(string n, logic [31:0] i, logic z, int a, int m, logic [3:0] al,
                              logic ac, logic s, logic l, logic w, logic r, logic p, logic e);
    row_t x;
    x.name = n; x.instr = i; x.zero = z; x.ack = a; x.mcyc = m; x.alu = al;
    x.achk = ac; x.src = s; x.lw = l; x.sw = w; x.rw = r; x.pcs = p; x.err = e;
    return x;
  endfunction

  function automatic exp_t ex(logic [2:0] s, logic sr, logic [3:0] al, logic ck, logic rd, logic wr,
                              logic m2r, logic rw, logic lpc, logic pcs, logic er);
    exp_t e;
    e.st = s; e.src = sr; e.alu = al; e.chk = ck; e.rd = rd; e.wr = wr;
    e.m2r = m2r; e.rw = rw; e.lpc = lpc; e.pcs = pcs; e.err = er;
    return e;
  endfunction

  task automatic step(input exp_t e);
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run_row(input row_t r);
    cur_tag = r.name;
    bif.instr = r.instr; bif.zero = ~r.zero; bif.dmem_ack = 1'b0;
    step(ex(3'd0, 0, 4'd0, after_rst, 0, 0, 0, 0, 0, 0, err_model));
    after_rst = 1'b0;
    step(ex(3'd1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, err_model));
    bif.instr = 32'hFFFF_FFFF; bif.zero = r.zero;
    step(ex(3'd2, r.src, r.alu, r.achk, 0, 0, 0, 0, 0, 0, err_model));
    bif.zero = ~r.zero;
    for (int j = 1; j <= r.mcyc; j++) begin
      bif.dmem_ack = (j == r.ack);
      step(ex(3'd3, r.src, r.alu, r.achk, r.lw, r.sw, 0, 0, 0, 0, err_model));
    end
    bif.dmem_ack = 1'b1;
    err_model = r.err;
    step(ex(3'd4, r.src, r.alu, r.achk, 0, 0, r.lw, r.rw, 1, r.pcs, err_model));
    bif.dmem_ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e, g;
      e = q.pop_front();
      g.st = bif.state; g.src = bif.alu_src; g.alu = e.chk ? bif.alu_ctrl : e.alu;
      g.rd = bif.mem_read; g.wr = bif.mem_write; g.m2r = bif.mem_to_reg;
      g.rw = bif.reg_write; g.lpc = bif.load_pc; g.pcs = bif.pc_src;
      g.err = bif.mem_err; g.chk = e.chk;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s st=%0d got=%h exp=%h (st,src,alu,rd,wr,m2r,rw,lpc,pcs,err,chk)",
                 cur_tag, e.st, g, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    tbl.push_back(mk("add",     32'h002081B3, 0, 0, 1,  4'h2, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("beq_t",   32'h00208463, 1, 0, 1,  4'h6, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("beq_nt",  32'h00208463, 0, 0, 1,  4'h6, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lw_ack3", 32'h0000A183, 0, 3, 3,  4'h2, 1, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk("sw_ack15",32'h0020A023, 0, 15,15, 4'h2, 1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("sub",     32'h402081B3, 0, 1, 1,  4'h6, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("srai",    32'h4040D193, 0, 0, 1,  4'hA, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("addi_b30",32'h40008193, 0, 0, 1,  4'h2, 1, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk("xor",     32'h0020C1B3, 1, 0, 1,  4'hD, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("slt",     32'h0020A1B3, 0, 0, 1,  4'h7, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk("nop7f",   32'h0000007F, 1, 1, 1,  4'h0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sw_tmo",  32'h0020A023, 0, 0, 15, 4'h2, 1, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk("add_err", 32'h002081B3, 0, 0, 1,  4'h2, 1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk("lw_tmo",  32'h0000A183, 0, 0, 15, 4'h2, 1, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk("lw_ack1", 32'h0000A183, 0, 1, 1,  4'h2, 1, 1, 1, 0, 1, 0, 1));

    rst = 1'b1;
    bif.instr = '0; bif.zero = 1'b0; bif.dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    after_rst = 1'b1;

    foreach (tbl[i]) run_row(tbl[i]);

    cur_tag = "rst_mid";
    bif.instr = 32'h0000A183; bif.zero = 1'b0; bif.dmem_ack = 1'b0;
    step(ex(3'd0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1));
    step(ex(3'd1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1));
    bif.instr = 32'hFFFF_FFFF;
    step(ex(3'd2, 1, 4'h2, 1, 0, 0, 0, 0, 0, 0, 1));
    step(ex(3'd3, 1, 4'h2, 1, 1, 0, 0, 0, 0, 0, 1));
    step(ex(3'd3, 1, 4'h2, 1, 1, 0, 0, 0, 0, 0, 1));
    rst = 1'b1;
    step(ex(3'd3, 1, 4'h2, 1, 1, 0, 0, 0, 0, 0, 1));
    rst = 1'b0;
    checks++;
    if (bif.state !== 3'd0) begin
      errors++;
      $display("FAIL rst_mid state=%0d exp 0", bif.state);
    end
    checks++;
    if (bif.mem_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid mem_err=%b exp 0", bif.mem_err);
    end
    checks++;
    if (bif.reg_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid reg_write=%b exp 0", bif.reg_write);
    end
    checks++;
    if (bif.load_pc !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid load_pc=%b exp 0", bif.load_pc);
    end
    err_model = 1'b0;
    after_rst = 1'b1;
    run_row(mk("add_post_rst", 32'h002081B3, 0, 0, 1, 4'h2, 1, 0, 0, 0, 1, 0, 0));

    repeat (2) @(negedge clk);
    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks: %0d", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
